rom_burst_reader: RTL and testbench

//   Address sequencer and output register stage placed directly upstream of
//   the 16-entry combinational ROM lookup table. On a start command it walks
//   ROM addresses from start_addr for burst_len entries, drives rom_addr,

---
 rtl/rom_burst_reader.sv | 125 ++++++++++++
 tb/tb_rom_burst_reader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_burst_reader.sv
`default_nettype none
// ============================================================================
// rom_burst_reader : walks a ROM LUT for a burst and streams the words out
//                    on a valid/ready interface with last and done markers.
// Revision: 1.0
// ============================================================================
module rom_burst_reader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   burst_len,
    input  logic              abort,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [ADDR_W:0]     r_remaining;
    logic [ADDR_W:0]     w_remaining_nxt;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   w_data_nxt;
    logic                r_valid;
    logic                w_valid_nxt;
    logic                r_last;
    logic                w_last_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_remaining <= w_remaining_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_last      <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_remaining_nxt = r_remaining;
        w_data_nxt      = r_data;
        w_valid_nxt     = r_valid;
        w_last_nxt      = r_last;

        case (r_state)
            S_IDLE: begin
                if (start && (burst_len != '0)) begin
                    w_addr_nxt      = start_addr;
                    w_remaining_nxt = burst_len;
                    w_state_nxt     = S_FETCH;
                end
            end
            S_FETCH: begin
                w_data_nxt  = rom_data;
                w_valid_nxt = 1'b1;
                w_last_nxt  = (r_remaining == (ADDR_W+1)'(1));
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (r_valid && out_ready) begin
                    w_valid_nxt = 1'b0;
                    if (r_last) begin
                        w_last_nxt  = 1'b0;
                        w_state_nxt = S_DONE;
                    end else begin
                        // Address wraps naturally at the ROM depth.
                        w_addr_nxt      = r_addr + 1'b1;
                        w_remaining_nxt = r_remaining - 1'b1;
                        w_state_nxt     = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort overrides everything, including a coincident last handshake.
        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
        end
    end

    assign rom_addr  = r_addr;
    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign out_last  = r_last;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_rom_burst_reader.sv
`default_nettype none
// ============================================================================
// tb_rom_burst_reader : randomized self-checking bench for rom_burst_reader.
// Revision: 1.0
// ============================================================================
module tb_rom_burst_reader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] start_addr;
    logic [4:0] burst_len;
    logic       abort;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       busy;
    logic       done;

    int vectors;
    int miscompares;

    rom_burst_reader #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .burst_len  (burst_len),
        .abort      (abort),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    // ROM contents: entry n holds 0xnn.
    assign rom_data = {rom_addr, rom_addr};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_word(input logic [3:0] sa, input int idx);
        int a;
        a = (int'(sa) + idx) % 16;
        return 8'(a * 17);
    endfunction

    // mode: 0 ready always high, 1 random ready plus stray start pulses,
    //       2 ready withheld for 5 cycles on the second word.
    // kill_kind: 0 none, 1 abort, 2 reset, applied while word kill_word is held.
    task automatic run_burst(input logic [3:0] sa, input logic [4:0] len,
                             input int mode, input int kill_kind, input int kill_word);
        int  idx;
        int  cyc;
        int  dones;
        int  stall;
        bit  fin;
        bit  first;
        bit  exp_hold;
        bit  exp_gap;
        idx = 0; cyc = 0; dones = 0; stall = 0;
        fin = 0; first = 1; exp_hold = 0; exp_gap = 0;

        @(negedge clk);
        start = 1'b1; start_addr = sa; burst_len = len; abort = 1'b0;
        out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("fetch_busy", busy, 1);
        chk("fetch_no_valid", out_valid, 0);

        while (!fin && cyc < 300) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            abort = 1'b0;
            if (first) begin
                chk("first_valid_latency", out_valid, 1);
                first = 0;
            end
            if (exp_hold) chk("valid_held", out_valid, 1);
            if (exp_gap)  chk("fetch_gap", out_valid, 0);
            exp_hold = 0;
            exp_gap  = 0;

            if (done) begin
                dones++;
                chk("done_word_count", idx, 32'(len));
                chk("done_busy", busy, 1);
                chk("done_valid", out_valid, 0);
                chk("done_last", out_last, 0);
                fin = 1;
            end else if (out_valid) begin
                chk("data", out_data, model_word(sa, idx));
                chk("last", out_last, (idx == int'(len) - 1) ? 1 : 0);
                if (kill_kind != 0 && idx == kill_word) begin
                    out_ready = 1'b0;
                    if (kill_kind == 1) abort = 1'b1;
                    else                rst_n = 1'b0;
                    @(negedge clk);
                    abort = 1'b0;
                    rst_n = 1'b1;
                    chk("kill_valid", out_valid, 0);
                    chk("kill_busy", busy, 0);
                    chk("kill_last", out_last, 0);
                    chk("kill_done", done, 0);
                    repeat (4) begin
                        @(negedge clk);
                        if (done) dones++;
                        chk("kill_stays_idle", busy, 0);
                    end
                    chk("kill_no_done", dones, 0);
                    return;
                end
                if (mode == 1) begin
                    out_ready = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 3) == 0) begin
                        start      = 1'b1;
                        start_addr = 4'($urandom);
                        burst_len  = 5'($urandom_range(1, 16));
                    end
                end else if (mode == 2 && idx == 1 && stall < 5) begin
                    out_ready = 1'b0;
                    stall++;
                end else begin
                    out_ready = 1'b1;
                end
                if (out_ready) begin
                    idx++;
                    exp_gap = (idx < int'(len));
                end else begin
                    exp_hold = 1;
                end
            end
        end
        start = 1'b0;
        chk("burst_completed", fin, 1);
        chk("done_pulses", dones, 1);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_valid", out_valid, 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clk         = 1'b0;
        rst_n       = 1'b0;
        start       = 1'b1;
        start_addr  = 4'd3;
        burst_len   = 5'd4;
        abort       = 1'b0;
        out_ready   = 1'b1;

        // Reset held with start asserted.
        repeat (3) begin
            @(negedge clk);
            chk("rst_busy", busy, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_last", out_last, 0);
            chk("rst_done", done, 0);
            chk("rst_addr", rom_addr, 0);
            chk("rst_data", out_data, 0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);

        run_burst(4'h2, 5'd4, 0, 0, 0);
        run_burst(4'hE, 5'd4, 0, 0, 0);
        run_burst(4'h7, 5'd4, 2, 0, 0);

        // Zero-length request is ignored.
        @(negedge clk);
        start = 1'b1; start_addr = 4'h9; burst_len = 5'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            chk("len0_busy", busy, 0);
            chk("len0_valid", out_valid, 0);
            @(negedge clk);
        end

        run_burst(4'h0, 5'd16, 0, 0, 0);
        run_burst(4'h3, 5'd6, 1, 0, 0);
        run_burst(4'hA, 5'd5, 0, 1, 1);
        run_burst(4'h5, 5'd1, 0, 0, 0);
        run_burst(4'hC, 5'd7, 0, 2, 1);
        run_burst(4'h5, 5'd1, 0, 0, 0);

        for (int n = 0; n < 20; n++) begin
            logic [3:0] sa;
            logic [4:0] len;
            int         kk;
            sa  = 4'($urandom);
            len = 5'($urandom_range(1, 16));
            kk  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            run_burst(sa, len, 1, kk, $urandom_range(0, int'(len) - 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
